ann_mac_scheduler: RTL and testbench
====================================

// Module: ann_mac_scheduler
// PURPOSE
//  Sequencer for the drowsiness-detector ANN (30 in -> 5 hidden -> 3 out) sharing one MAC.
//  Issues per-cycle weight/input indices and MAC, activation and weight-update strobes.
//  Runs a forward pass, then (if training) a weight-update sweep over both layers.
//  Sits between top-level Start/training control and the MAC/activation/weight-RAM datapath.
// PARAMETERS
//  N_IN    30  inputs per sample (hidden-layer fan-in)
//  N_HID   5   hidden neurons (output-layer fan-in)
//  N_OUT   3   output neurons
//  MAC_LAT 2   MAC pipeline depth; drain cycles before the accumulator is valid
//  IW = $clog2(max(N_IN,N_HID)), NW = $clog2(max(N_HID,N_OUT))   (localparams)
// PORTS
//  Clock     in   1   single clock, rising edge
//  Rst       in   1   asynchronous reset, active-high
//  Start     in   1   level; sampled in IDLE only
//  training  in   1   sampled with Start; latched for the whole pass
//  abort     in   1   synchronous abort -> IDLE next cycle
//  hold      in   1   stall: freezes state/counters, forces strobes low
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle pulse in DONE
//  state     out  4   current FSM encoding (below)
//  layer     out  1   0 = hidden, 1 = output
//  neu_idx   out  NW  current neuron
//  in_idx    out  IW  current input / hidden-activation index
//  mac_clr   out  1   with mac_en on first term of a neuron (clear-and-load)
//  mac_en    out  1   one product accumulated this cycle
//  act_en    out  1   latch activation of neu_idx/layer
//  wu_en     out  1   update weight [layer][neu_idx][in_idx]
//  pass_cnt  out  16  completed passes, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset: state=IDLE(0), all outputs 0, counters 0, latched training 0.
//  States: IDLE=0 HMAC=1 HDRN=2 HACT=3 OMAC=4 ODRN=5 OACT=6 UOUT=7 UHID=8 DONE=9.
//  IDLE: Start&!abort -> HMAC, latch training; indices 0.
//  HMAC: mac_en=1 for in_idx 0..N_IN-1 (mac_clr at 0); after N_IN-1 -> HDRN.
//  HDRN: MAC_LAT cycles, strobes low -> HACT. MAC_LAT=0 skips HDRN.
//  HACT: act_en=1 one cycle; next neuron -> HMAC, or after last hidden -> OMAC, layer=1.
//  OMAC/ODRN/OACT: same with fan-in N_HID over N_OUT neurons; after last -> UOUT if
//   training latched, else DONE.
//  UOUT: wu_en each cycle, in_idx fastest, N_OUT*N_HID cycles -> UHID (layer=0).
//  UHID: wu_en, N_HID*N_IN cycles -> DONE.
//  DONE: done=1, pass_cnt+1, -> IDLE; Start still high restarts the cycle after.
//  Defaults: forward 189 cycles (5*33 + 3*8); training adds 15+150 = 354.
//  hold: no state/counter change; mac_en/mac_clr/act_en/wu_en=0; indices held; done
//   cannot pulse while held (DONE persists until hold drops).
//  abort: beats hold and Start; any state -> IDLE next edge, pass_cnt unchanged.
//  training/Start changes mid-pass are ignored. Rst mid-pass: immediate return to reset values.
//  Indices wrap to 0 at every layer/neuron boundary; never exceed fan-in-1 / count-1.
// TESTING
//  Inference: Rst pulse, Start=1 training=0 one cycle -> 30 mac_en then 2 idle then act_en
//   per hidden neuron; done at cycle 190 after Start edge; pass_cnt=1.
//  Training: Start=1 training=1 -> wu_en count 165 (15 layer1, 150 layer0); done at cycle
//   355; mac_en total 165; act_en total 8.
//  Hold: hold=1 for 10 cycles at in_idx=12 of neuron 2 -> indices frozen, strobes 0;
//   done delayed exactly 10 cycles.
//  Abort in UHID -> state 0 next cycle, busy=0, done never pulses, pass_cnt unchanged.
//  Start held high 3 passes -> done every 190 cycles, pass_cnt=3; async Rst mid-OMAC ->
//   all outputs 0 before next edge.

Source files
------------

// File: rtl/ann_mac_scheduler.sv
// Sequencer for a 30-5-3 ANN sharing one MAC: forward pass over both layers,
// then an optional weight-update sweep (output layer first, then hidden layer).
module ann_mac_scheduler #(
    parameter int N_IN    = 30,
    parameter int N_HID   = 5,
    parameter int N_OUT   = 3,
    parameter int MAC_LAT = 2,
    localparam int IW = $clog2((N_IN > N_HID) ? N_IN : N_HID),
    localparam int NW = $clog2((N_HID > N_OUT) ? N_HID : N_OUT)
) (
    input  logic          Clock,
    input  logic          Rst,
    input  logic          Start,
    input  logic          training,
    input  logic          abort,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic [3:0]    state,
    output logic          layer,
    output logic [NW-1:0] neu_idx,
    output logic [IW-1:0] in_idx,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          act_en,
    output logic          wu_en,
    output logic [15:0]   pass_cnt
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_HMAC = 4'd1, S_HDRN = 4'd2, S_HACT = 4'd3, S_OMAC = 4'd4,
        S_ODRN = 4'd5, S_OACT = 4'd6, S_UOUT = 4'd7, S_UHID = 4'd8, S_DONE = 4'd9
    } state_t;

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DW-1:0] DRN_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
    localparam logic [IW-1:0] HID_FAN  = IW'(N_HID - 1);
    localparam logic [NW-1:0] HID_LAST = NW'(N_HID - 1);
    localparam logic [NW-1:0] OUT_LAST = NW'(N_OUT - 1);

    state_t        state_q, state_n;
    logic [IW-1:0] in_n;
    logic [NW-1:0] neu_n;
    logic          layer_n, trn_q, trn_n;
    logic [DW-1:0] drn_q, drn_n;
    logic [15:0]   cnt_n;
    logic          mac_en_c, mac_clr_c, act_en_c, wu_en_c, done_c;
    logic          go;

    // Strobes only fire on cycles that actually advance the sequence.
    assign go      = !hold && !abort;
    assign state   = state_q;
    assign busy    = (state_q != S_IDLE);
    assign mac_en  = mac_en_c  & go;
    assign mac_clr = mac_clr_c & go;
    assign act_en  = act_en_c  & go;
    assign wu_en   = wu_en_c   & go;
    assign done    = done_c    & go;

    always_comb begin
        state_n   = state_q;
        in_n      = in_idx;
        neu_n     = neu_idx;
        layer_n   = layer;
        drn_n     = drn_q;
        trn_n     = trn_q;
        cnt_n     = pass_cnt;
        mac_en_c  = 1'b0;
        mac_clr_c = 1'b0;
        act_en_c  = 1'b0;
        wu_en_c   = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_IDLE: if (Start) begin
                state_n = S_HMAC;
                trn_n   = training;
                in_n    = '0;
                neu_n   = '0;
                layer_n = 1'b0;
            end
            S_HMAC, S_OMAC: begin
                mac_en_c  = 1'b1;
                mac_clr_c = (in_idx == '0);
                if (in_idx == ((state_q == S_HMAC) ? IN_LAST : HID_FAN)) begin
                    in_n  = '0;
                    drn_n = '0;
                    if (MAC_LAT == 0) state_n = (state_q == S_HMAC) ? S_HACT : S_OACT;
                    else              state_n = (state_q == S_HMAC) ? S_HDRN : S_ODRN;
                end else begin
                    in_n = in_idx + IW'(1);
                end
            end
            S_HDRN, S_ODRN: begin
                if (drn_q == DRN_LAST) state_n = (state_q == S_HDRN) ? S_HACT : S_OACT;
                else                   drn_n   = drn_q + DW'(1);
            end
            S_HACT: begin
                act_en_c = 1'b1;
                if (neu_idx == HID_LAST) begin
                    neu_n   = '0;
                    layer_n = 1'b1;
                    state_n = S_OMAC;
                end else begin
                    neu_n   = neu_idx + NW'(1);
                    state_n = S_HMAC;
                end
            end
            S_OACT: begin
                act_en_c = 1'b1;
                if (neu_idx == OUT_LAST) begin
                    neu_n   = '0;
                    layer_n = trn_q;
                    state_n = trn_q ? S_UOUT : S_DONE;
                end else begin
                    neu_n   = neu_idx + NW'(1);
                    state_n = S_OMAC;
                end
            end
            S_UOUT, S_UHID: begin
                wu_en_c = 1'b1;
                if (in_idx == ((state_q == S_UOUT) ? HID_FAN : IN_LAST)) begin
                    in_n = '0;
                    if (neu_idx == ((state_q == S_UOUT) ? OUT_LAST : HID_LAST)) begin
                        neu_n   = '0;
                        layer_n = 1'b0;
                        state_n = (state_q == S_UOUT) ? S_UHID : S_DONE;
                    end else begin
                        neu_n = neu_idx + NW'(1);
                    end
                end else begin
                    in_n = in_idx + IW'(1);
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                cnt_n   = pass_cnt + 16'd1;
                // A held Start chains straight into the next pass (190-cycle period).
                state_n = Start ? S_HMAC : S_IDLE;
                trn_n   = Start ? training : trn_q;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            in_idx   <= '0;
            neu_idx  <= '0;
            layer    <= 1'b0;
            drn_q    <= '0;
            trn_q    <= 1'b0;
            pass_cnt <= '0;
        end else if (abort) begin
            state_q <= S_IDLE;
            in_idx  <= '0;
            neu_idx <= '0;
            layer   <= 1'b0;
            drn_q   <= '0;
        end else if (!hold) begin
            state_q  <= state_n;
            in_idx   <= in_n;
            neu_idx  <= neu_n;
            layer    <= layer_n;
            drn_q    <= drn_n;
            trn_q    <= trn_n;
            pass_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_ann_mac_scheduler.sv
// Directed bench for ann_mac_scheduler: inference, training, hold, abort,
// back-to-back passes and asynchronous reset.
module tb_ann_mac_scheduler;
    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        training = 1'b0;
    logic        abort = 1'b0;
    logic        hold = 1'b0;
    logic        busy, done, layer, mac_clr, mac_en, act_en, wu_en;
    logic [3:0]  state;
    logic [2:0]  neu_idx;
    logic [4:0]  in_idx;
    logic [15:0] pass_cnt;

    int checks = 0;
    int failures = 0;

    int done_cyc[3];
    int n_done, mac_cnt, clr_cnt, act_cnt, wu_cnt, wu_l1, drn_cnt, first_act;
    int max_in, max_neu, held_bad, hin, hneu;
    logic [3:0] st_ab;
    logic       busy_ab;

    ann_mac_scheduler dut (
        .Clock(Clock), .Rst(Rst), .Start(Start), .training(training), .abort(abort),
        .hold(hold), .busy(busy), .done(done), .state(state), .layer(layer),
        .neu_idx(neu_idx), .in_idx(in_idx), .mac_clr(mac_clr), .mac_en(mac_en),
        .act_en(act_en), .wu_en(wu_en), .pass_cnt(pass_cnt)
    );

    always #5 Clock = ~Clock;

    // Cycle k = k-th cycle after the edge that samples Start; sampled 1ns after negedge.
    task automatic run_pass(input bit trn, input int ndone, input int h0, input int hl,
                            input int a0, input int maxc);
        @(negedge Clock);
        Start = 1'b1;
        training = trn;
        @(posedge Clock);
        #1;
        if (ndone == 1) Start = 1'b0;
        training = 1'b0;
        n_done = 0; mac_cnt = 0; clr_cnt = 0; act_cnt = 0; wu_cnt = 0; wu_l1 = 0;
        drn_cnt = 0; first_act = 0; max_in = 0; max_neu = 0; held_bad = 0;
        hin = -1; hneu = -1; st_ab = 4'hF; busy_ab = 1'b1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge Clock);
            hold  = (k >= h0) && (k < h0 + hl);
            abort = (k == a0);
            #1;
            mac_cnt += int'(mac_en);
            clr_cnt += int'(mac_clr);
            act_cnt += int'(act_en);
            wu_cnt  += int'(wu_en);
            wu_l1   += int'(wu_en && layer);
            drn_cnt += int'(state == 4'd2);
            if (act_en && first_act == 0) first_act = k;
            if (int'(in_idx) > max_in) max_in = int'(in_idx);
            if (int'(neu_idx) > max_neu) max_neu = int'(neu_idx);
            if (k == h0) begin hin = int'(in_idx); hneu = int'(neu_idx); end
            if (hold && (int'(in_idx) != hin || int'(neu_idx) != hneu ||
                         mac_en || mac_clr || act_en || wu_en || done)) held_bad++;
            if (k == a0 + 1) begin st_ab = state; busy_ab = busy; end
            if (done) begin
                if (n_done < 3) done_cyc[n_done] = k;
                n_done++;
                if (n_done == ndone) begin
                    Start = 1'b0;
                    break;
                end
            end
        end
        hold = 1'b0; abort = 1'b0; Start = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({state, busy, done, layer, neu_idx, in_idx, mac_clr, mac_en, act_en, wu_en} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: state=%0d busy=%0b done=%0b in=%0d neu=%0d", state, busy, done, in_idx, neu_idx);
        end
        checks++;
        if (pass_cnt !== 16'd0) begin failures++; $display("FAIL reset_pass_cnt: got %0d want 0", pass_cnt); end
        @(negedge Clock);
        Rst = 1'b0;
    endtask

    task automatic test_inference();
        run_pass(1'b0, 1, 0, 0, 0, 400);
        checks++;
        if (n_done != 1 || done_cyc[0] != 190) begin failures++; $display("FAIL inf_done_cycle: got %0d (n=%0d) want 190", done_cyc[0], n_done); end
        checks++;
        if (mac_cnt != 165 || clr_cnt != 8) begin failures++; $display("FAIL inf_mac: mac=%0d clr=%0d want 165/8", mac_cnt, clr_cnt); end
        checks++;
        if (act_cnt != 8 || wu_cnt != 0) begin failures++; $display("FAIL inf_act_wu: act=%0d wu=%0d want 8/0", act_cnt, wu_cnt); end
        checks++;
        if (first_act != 33 || drn_cnt != 10) begin failures++; $display("FAIL inf_drain: first_act=%0d hdrn=%0d want 33/10", first_act, drn_cnt); end
        checks++;
        if (max_in != 29 || max_neu != 4) begin failures++; $display("FAIL inf_idx_range: in=%0d neu=%0d want 29/4", max_in, max_neu); end
        checks++;
        if (pass_cnt !== 16'd1 || state !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL inf_end: cnt=%0d state=%0d busy=%0b want 1/0/0", pass_cnt, state, busy); end
    endtask

    task automatic test_training();
        run_pass(1'b1, 1, 0, 0, 0, 500);
        checks++;
        if (n_done != 1 || done_cyc[0] != 355) begin failures++; $display("FAIL trn_done_cycle: got %0d want 355", done_cyc[0]); end
        checks++;
        if (wu_cnt != 165 || wu_l1 != 15) begin failures++; $display("FAIL trn_wu: total=%0d layer1=%0d want 165/15", wu_cnt, wu_l1); end
        checks++;
        if (mac_cnt != 165 || act_cnt != 8) begin failures++; $display("FAIL trn_mac_act: mac=%0d act=%0d want 165/8", mac_cnt, act_cnt); end
        checks++;
        if (pass_cnt !== 16'd2) begin failures++; $display("FAIL trn_pass_cnt: got %0d want 2", pass_cnt); end
    endtask

    task automatic test_hold();
        run_pass(1'b0, 1, 79, 10, 0, 400);
        checks++;
        if (hin != 12 || hneu != 2) begin failures++; $display("FAIL hold_point: in=%0d neu=%0d want 12/2", hin, hneu); end
        checks++;
        if (held_bad != 0) begin failures++; $display("FAIL hold_frozen: %0d bad cycles want 0", held_bad); end
        checks++;
        if (done_cyc[0] != 200 || mac_cnt != 165) begin failures++; $display("FAIL hold_delay: done=%0d mac=%0d want 200/165", done_cyc[0], mac_cnt); end
        checks++;
        if (pass_cnt !== 16'd3) begin failures++; $display("FAIL hold_pass_cnt: got %0d want 3", pass_cnt); end
    endtask

    task automatic test_abort();
        run_pass(1'b1, 1, 0, 0, 250, 400);
        checks++;
        if (st_ab !== 4'd0 || busy_ab !== 1'b0) begin failures++; $display("FAIL abort_idle: state=%0d busy=%0b want 0/0", st_ab, busy_ab); end
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL abort_done: %0d pulses want 0", n_done); end
        checks++;
        if (pass_cnt !== 16'd3) begin failures++; $display("FAIL abort_pass_cnt: got %0d want 3", pass_cnt); end
    endtask

    task automatic test_back_to_back();
        run_pass(1'b0, 3, 0, 0, 0, 700);
        checks++;
        if (n_done != 3 || done_cyc[0] != 190 || done_cyc[1] != 380 || done_cyc[2] != 570) begin
            failures++;
            $display("FAIL b2b_period: n=%0d at %0d/%0d/%0d want 190/380/570", n_done, done_cyc[0], done_cyc[1], done_cyc[2]);
        end
        checks++;
        if (pass_cnt !== 16'd6) begin failures++; $display("FAIL b2b_pass_cnt: got %0d want 6", pass_cnt); end
    endtask

    task automatic test_async_reset();
        @(negedge Clock);
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (170) @(negedge Clock);
        #1;
        checks++;
        if (state !== 4'd4 || layer !== 1'b1) begin failures++; $display("FAIL arst_pre: state=%0d layer=%0b want 4/1", state, layer); end
        Rst = 1'b1;
        #1;
        checks++;
        if ({state, busy, done, layer, neu_idx, in_idx, mac_clr, mac_en, act_en, wu_en} !== '0 || pass_cnt !== 16'd0) begin
            failures++;
            $display("FAIL arst_outputs: state=%0d in=%0d neu=%0d cnt=%0d want all 0", state, in_idx, neu_idx, pass_cnt);
        end
        @(negedge Clock);
        Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inference();
        test_training();
        test_hold();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
